mem_access_arbiter: RTL and testbench

//  Shares the single 8x32 data-memory port between two requesters: req0 = fetch/debug, req1 = load/store.

---
 rtl/mem_access_arbiter_pkg.sv | 15 +
 rtl/mem_access_arbiter_if.sv | 31 +++
 rtl/mem_access_arbiter_rr_arb2.sv | 16 +
 rtl/mem_access_arbiter.sv | 89 ++++++++
 tb/tb_mem_access_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_arbiter_pkg.sv
// mem_arb_pkg: shared sizes and FSM state encoding for the memory access arbiter.
//  MEM_SIZE  number of memory words (2**ADDR_W)
//  DATA_W    default memory word / requester data width
//  ADDR_W    default memory address width
//  state_t   arbiter FSM states; the unused code 2'd3 recovers to ST_IDLE
package mem_arb_pkg;
   localparam int MEM_SIZE = 8;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 3;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;
endpackage

// File: rtl/mem_access_arbiter_if.sv
// mem_access_arbiter_if: requester and memory-port signals of the two-way memory arbiter.
//  req/req_we/req_add/req_data  per-requester command, requester 0 in the low slice
//  gnt/done                     one-cycle grant and completion pulses
//  rd_data                      read result returned with done
//  mem_wr_en/mem_rd_en/mem_add/mem_data  memory command, mem_rd_data memory read data
//  master: requesters plus memory side; slave: the arbiter
interface mem_access_arbiter_if #(
   parameter int DATA_W = mem_arb_pkg::DATA_W,
   parameter int ADDR_W = mem_arb_pkg::ADDR_W
);
   logic [1:0]          req;
   logic [1:0]          req_we;
   logic [2*ADDR_W-1:0] req_add;
   logic [2*DATA_W-1:0] req_data;
   logic [1:0]          gnt;
   logic [1:0]          done;
   logic [DATA_W-1:0]   rd_data;
   logic                mem_wr_en;
   logic                mem_rd_en;
   logic [ADDR_W-1:0]   mem_add;
   logic [DATA_W-1:0]   mem_data;
   logic [DATA_W-1:0]   mem_rd_data;
   modport master (
      output req, req_we, req_add, req_data, mem_rd_data,
      input  gnt, done, rd_data, mem_wr_en, mem_rd_en, mem_add, mem_data
   );
   modport slave (
      input  req, req_we, req_add, req_data, mem_rd_data,
      output gnt, done, rd_data, mem_wr_en, mem_rd_en, mem_add, mem_data
   );
endinterface

// File: rtl/mem_access_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick.
//  req      request vector
//  rr_last  index of the previous winner; the other requester wins a tie
//  win      one-hot winner (zero when nobody requests)
//  valid    some requester is active
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       rr_last,
   output logic [1:0] win,
   output logic       valid
);
   always_comb begin
      win = &req ? (rr_last ? 2'b01 : 2'b10) : req;
      valid = |req;
   end
endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one memory port between two requesters, one access in flight.
//  clk    rising-edge clock
//  rst_n  asynchronous active-low reset
//  bus    slave side of mem_access_arbiter_if (requester commands, gnt/done/rd_data, memory port)
// Each access takes ISSUE (gnt + memory enables) then RESP (done + rd_data); arbitration
// for the next access runs in IDLE and RESP so back-to-back accesses complete every 2 cycles.
module mem_access_arbiter #(
   parameter int DATA_W = mem_arb_pkg::DATA_W,
   parameter int ADDR_W = mem_arb_pkg::ADDR_W
) (
   input logic                 clk,
   input logic                 rst_n,
   mem_access_arbiter_if.slave bus
);
   import mem_arb_pkg::*;
   state_t              state;
   logic                rr_last;
   logic [1:0]          win;
   logic                valid;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_add;
   logic [DATA_W-1:0]   sel_data;
   logic [1:0]          gnt_q;
   logic [1:0]          done_q;
   logic                wr_q;
   logic                rd_q;
   logic [ADDR_W-1:0]   add_q;
   logic [DATA_W-1:0]   data_q;
   logic [DATA_W-1:0]   rd_data_q;
   rr_arb2 u_arb (
      .req     (bus.req),
      .rr_last (rr_last),
      .win     (win),
      .valid   (valid)
   );
   // Command of the winning requester; win[1] is the winner index.
   always_comb begin
      sel_we = win[1] ? bus.req_we[1] : bus.req_we[0];
      sel_add = win[1] ? bus.req_add[2*ADDR_W-1:ADDR_W] : bus.req_add[ADDR_W-1:0];
      sel_data = win[1] ? bus.req_data[2*DATA_W-1:DATA_W] : bus.req_data[DATA_W-1:0];
   end
   // mem_add/mem_data registers double as the command latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         rr_last <= 1'b1;
         gnt_q <= '0;
         done_q <= '0;
         wr_q <= 1'b0;
         rd_q <= 1'b0;
         add_q <= '0;
         data_q <= '0;
         rd_data_q <= '0;
      end else begin
         gnt_q <= '0;
         done_q <= '0;
         wr_q <= 1'b0;
         rd_q <= 1'b0;
         case (state)
            ST_ISSUE: begin
               state <= ST_RESP;
               done_q <= gnt_q;
               if (rd_q) rd_data_q <= bus.mem_rd_data;
            end
            ST_IDLE, ST_RESP: begin
               if (valid) begin
                  state <= ST_ISSUE;
                  rr_last <= win[1];
                  gnt_q <= win;
                  wr_q <= sel_we;
                  rd_q <= !sel_we;
                  add_q <= sel_add;
                  data_q <= sel_data;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
   assign bus.gnt = gnt_q;
   assign bus.done = done_q;
   assign bus.rd_data = rd_data_q;
   assign bus.mem_wr_en = wr_q;
   assign bus.mem_rd_en = rd_q;
   assign bus.mem_add = add_q;
   assign bus.mem_data = data_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed bench for mem_access_arbiter with an 8x32 memory model.
module tb_mem_access_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] mem [8];
   logic [31:0] rd;
   mem_access_arbiter_if bus ();
   mem_access_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   // Memory acts mid-cycle so read data is settled before the edge that ends ISSUE.
   always @(negedge clk) begin
      if (bus.mem_wr_en) mem[bus.mem_add] = bus.mem_data;
      if (bus.mem_rd_en) bus.mem_rd_data = mem[bus.mem_add];
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic set_cmd(input int w, input logic we, input logic [2:0] a, input logic [31:0] d);
      bus.req_we[w] = we;
      bus.req_add[w*3 +: 3] = a;
      bus.req_data[w*32 +: 32] = d;
   endtask
   task automatic access(input int w, input logic we, input logic [2:0] a, input logic [31:0] d,
                         output logic [31:0] r);
      int n;
      set_cmd(w, we, a, d);
      bus.req[w] = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.gnt[w] && n < 10);
      chk("acc_gnt", bus.gnt[w], 1);
      bus.req[w] = 1'b0;
      tick();
      chk("acc_done", bus.done[w], 1);
      r = bus.rd_data;
   endtask
   initial begin
      int nboth, ngnt, ndone;
      for (int i = 0; i < 8; i++) mem[i] = 32'h1000_0000 + i;
      bus.req = '0;
      bus.req_we = '0;
      bus.req_add = '0;
      bus.req_data = '0;
      // 1: reset asserted mid-cycle, then tie goes to req0
      #2 rst_n = 1'b0;
      #1;
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_wr_en", bus.mem_wr_en, 0);
      chk("rst_rd_en", bus.mem_rd_en, 0);
      chk("rst_add", bus.mem_add, 0);
      chk("rst_mem_data", bus.mem_data, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("idle_gnt", bus.gnt, 0);
      set_cmd(0, 0, 3'd0, 0);
      set_cmd(1, 0, 3'd1, 0);
      bus.req = 2'b11;
      tick();
      chk("first_gnt", bus.gnt, 2'b01);
      chk("first_rd_en", bus.mem_rd_en, 1);
      chk("first_wr_en", bus.mem_wr_en, 0);
      chk("first_add", bus.mem_add, 0);
      bus.req = 2'b10;
      tick();
      chk("first_done", bus.done, 2'b01);
      chk("first_rd", bus.rd_data, 32'h1000_0000);
      chk("resp_gnt", bus.gnt, 0);
      chk("resp_rd_en", bus.mem_rd_en, 0);
      tick();
      chk("second_gnt", bus.gnt, 2'b10);
      chk("second_add", bus.mem_add, 1);
      chk("second_no_done", bus.done, 0);
      bus.req = 2'b00;
      tick();
      chk("second_done", bus.done, 2'b10);
      chk("second_rd", bus.rd_data, 32'h1000_0001);
      tick();
      chk("back_idle_done", bus.done, 0);
      chk("back_idle_gnt", bus.gnt, 0);
      // 2: write then read back on requester 1
      set_cmd(1, 1, 3'd5, 32'hDEAD_BEEF);
      bus.req = 2'b10;
      tick();
      chk("wr_gnt", bus.gnt, 2'b10);
      chk("wr_wr_en", bus.mem_wr_en, 1);
      chk("wr_rd_en", bus.mem_rd_en, 0);
      chk("wr_add", bus.mem_add, 5);
      chk("wr_data", bus.mem_data, 32'hDEAD_BEEF);
      bus.req = 2'b00;
      tick();
      chk("wr_done", bus.done, 2'b10);
      chk("wr_keeps_rd", bus.rd_data, 32'h1000_0001);
      tick();
      set_cmd(1, 0, 3'd5, 0);
      bus.req = 2'b10;
      tick();
      chk("rd5_gnt", bus.gnt, 2'b10);
      bus.req = 2'b00;
      tick();
      chk("rd5_done", bus.done, 2'b10);
      chk("rd5_data", bus.rd_data, 32'hDEAD_BEEF);
      tick();
      // 3: contention, grants alternate every 2 cycles
      set_cmd(0, 0, 3'd2, 0);
      set_cmd(1, 0, 3'd3, 0);
      bus.req = 2'b11;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i % 2 == 0) begin
            chk("cont_gnt", bus.gnt, (i % 4 == 0) ? 2'b01 : 2'b10);
            chk("cont_excl", bus.mem_wr_en & bus.mem_rd_en, 0);
         end else begin
            chk("cont_done", bus.done, (i % 4 == 1) ? 2'b01 : 2'b10);
            chk("cont_rd", bus.rd_data, (i % 4 == 1) ? 32'h1000_0002 : 32'h1000_0003);
            chk("cont_gnt_gap", bus.gnt, 0);
         end
      end
      bus.req = 2'b00;
      tick();
      chk("cont_end_gnt", bus.gnt, 0);
      // 4: same requester back to back
      set_cmd(0, 0, 3'd2, 0);
      bus.req = 2'b01;
      tick();
      chk("b2b_gnt0", bus.gnt, 2'b01);
      chk("b2b_add0", bus.mem_add, 2);
      set_cmd(0, 0, 3'd3, 0);
      tick();
      chk("b2b_rd0", bus.rd_data, 32'h1000_0002);
      tick();
      chk("b2b_gnt1", bus.gnt, 2'b01);
      chk("b2b_add1", bus.mem_add, 3);
      bus.req = 2'b00;
      tick();
      chk("b2b_done1", bus.done, 2'b01);
      chk("b2b_rd1", bus.rd_data, 32'h1000_0003);
      tick();
      // 5: random traffic
      nboth = 0;
      ngnt = 0;
      ndone = 0;
      for (int i = 0; i < 10000; i++) begin
         bus.req = 2'($urandom_range(0, 3));
         bus.req_we = 2'($urandom_range(0, 3));
         bus.req_add = 6'($urandom_range(0, 63));
         bus.req_data = {$urandom, $urandom};
         tick();
         if ((bus.mem_wr_en && bus.mem_rd_en) || bus.gnt == 2'b11 || bus.done == 2'b11) nboth++;
         if (bus.gnt != 0) ngnt++;
         if (bus.done != 0) ndone++;
      end
      bus.req = 2'b00;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.done != 0) ndone++;
         if (bus.gnt != 0) ngnt++;
      end
      chk("rand_excl", nboth, 0);
      chk("rand_count", ngnt, ndone);
      chk("rand_active", ngnt > 1000, 1);
      // 6: reset during ISSUE of a write abandons it
      access(0, 1, 3'd7, 32'h7777_7777, rd);
      tick();
      set_cmd(0, 1, 3'd7, 32'hBAD0_0007);
      bus.req = 2'b01;
      tick();
      chk("abort_gnt", bus.gnt, 2'b01);
      chk("abort_wr_en", bus.mem_wr_en, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_wr_drop", bus.mem_wr_en, 0);
      chk("abort_gnt_drop", bus.gnt, 0);
      bus.req = 2'b00;
      tick();
      chk("abort_no_done", bus.done, 0);
      tick();
      rst_n = 1'b1;
      set_cmd(0, 0, 3'd7, 0);
      set_cmd(1, 0, 3'd4, 0);
      bus.req = 2'b11;
      tick();
      chk("post_rst_gnt", bus.gnt, 2'b01);
      bus.req = 2'b10;
      tick();
      chk("post_rst_done", bus.done, 2'b01);
      chk("mem7_kept", bus.rd_data, 32'h7777_7777);
      tick();
      chk("post_rst_gnt1", bus.gnt, 2'b10);
      bus.req = 2'b00;
      tick();
      chk("post_rst_done1", bus.done, 2'b10);
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
